// File: rtl/flash_mode_ctrl_if.sv
// rtl/flash_mode_ctrl_if.sv - lamp/request bundle for flash_mode_ctrl (sync pins with FLASH_SYNC_EN)
interface flash_mode_ctrl_if #(
  parameter int NUM_LANES = 2
);
  logic                 night_en;
  logic                 phase_mode;
  logic [NUM_LANES-1:0] lane_yellow;
  logic                 active;
  logic                 exit_done;
`ifdef FLASH_SYNC_EN
  logic                 sync_in;
  logic                 sync_out;

  modport master (
    output night_en, phase_mode, sync_in,
    input  lane_yellow, active, exit_done, sync_out
  );
  modport slave (
    input  night_en, phase_mode, sync_in,
    output lane_yellow, active, exit_done, sync_out
  );
`else
  modport master (
    output night_en, phase_mode,
    input  lane_yellow, active, exit_done
  );
  modport slave (
    input  night_en, phase_mode,
    output lane_yellow, active, exit_done
  );
`endif
endinterface

// File: rtl/flash_mode_ctrl.sv
// rtl/flash_mode_ctrl.sv - night/flash-mode lamp controller with entry/exit holds
// Optional phase-lock pins sync_in/sync_out enabled by FLASH_SYNC_EN.
module flash_mode_ctrl #(
  parameter int NUM_LANES   = 2,
  parameter int HALF_PERIOD = 1,
  parameter int ENTRY_HOLD  = 2,
  parameter int EXIT_HOLD   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  flash_mode_ctrl_if.slave   bus
);

  localparam int CNT_MAX_A = (HALF_PERIOD > ENTRY_HOLD) ? HALF_PERIOD : ENTRY_HOLD;
  localparam int CNT_MAX   = (CNT_MAX_A > EXIT_HOLD) ? CNT_MAX_A : EXIT_HOLD;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HP_LOAD    = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_HOLD - 1);
  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_HOLD - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ENTRY = 2'd1;
  localparam logic [1:0] FLASH = 2'd2;
  localparam logic [1:0] EXIT  = 2'd3;

  logic [1:0]           state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 ph, ph_d;
  logic                 mode_q, mode_d;
  logic                 done_d;
  logic                 active_d;
  logic [NUM_LANES-1:0] lane_d;
  logic                 sync_req;
  logic                 sync_out_d;

`ifdef FLASH_SYNC_EN
  assign sync_req = bus.sync_in;
`else
  assign sync_req = 1'b0;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ph_d    = ph;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.night_en) begin
          state_d = ENTRY;
          cnt_d   = ENTRY_LOAD;
          mode_d  = bus.phase_mode;
        end
      end
      ENTRY: begin
        if (cnt == '0) begin
          if (bus.night_en) begin
            state_d = FLASH;
            ph_d    = 1'b1;
            cnt_d   = HP_LOAD;
          end else begin
            state_d = EXIT;
            cnt_d   = EXIT_LOAD;
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      FLASH: begin
        // Exit is only taken at a half-period boundary and beats a sync request.
        if (cnt == '0 && !bus.night_en) begin
          state_d = EXIT;
          cnt_d   = EXIT_LOAD;
        end else if (sync_req) begin
          ph_d  = 1'b1;
          cnt_d = HP_LOAD;
        end else if (cnt == '0) begin
          ph_d  = ~ph;
          cnt_d = HP_LOAD;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      EXIT: begin
        if (cnt == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lamp pattern is derived from the next state so every output is a plain register.
  always_comb begin
    lane_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (state_d == FLASH)
        lane_d[i] = ph_d ^ (mode_d & ((i % 2) == 1));
      else if (state_d != IDLE)
        lane_d[i] = 1'b1;
    end
    active_d   = (state_d != IDLE);
    sync_out_d = (state_d == FLASH) && ph_d && !((state == FLASH) && ph);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      ph              <= 1'b0;
      mode_q          <= 1'b0;
      bus.lane_yellow <= '0;
      bus.active      <= 1'b0;
      bus.exit_done   <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      ph              <= ph_d;
      mode_q          <= mode_d;
      bus.lane_yellow <= lane_d;
      bus.active      <= active_d;
      bus.exit_done   <= done_d;
    end
  end

`ifdef FLASH_SYNC_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.sync_out <= 1'b0;
    else          bus.sync_out <= sync_out_d;
  end
`else
  logic unused_sync;
  assign unused_sync = sync_out_d;
`endif

endmodule

// File: tb/tb_flash_mode_ctrl.sv
// tb/tb_flash_mode_ctrl.sv - scoreboard bench for flash_mode_ctrl with random night/phase stimulus
module tb_flash_mode_ctrl;

  localparam int NL = 4;
  localparam int HP = 3;
  localparam int EH = 2;
  localparam int XH = 2;

  typedef struct {
    logic [NL-1:0] ly;
    logic          act;
    logic          done;
    logic          so;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  exp_t q[$];

  // Reference model: segment name + cycles elapsed in it, counted upward.
  int   m_seg;   // 0 idle, 1 entry hold, 2 blinking, 3 exit hold
  int   m_el;
  logic m_on;
  logic m_alt;

  flash_mode_ctrl_if #(.NUM_LANES(NL)) bus ();

  flash_mode_ctrl #(
    .NUM_LANES(NL), .HALF_PERIOD(HP), .ENTRY_HOLD(EH), .EXIT_HOLD(XH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seg = 0; m_el = 0; m_on = 1'b0; m_alt = 1'b0;
  endtask

  task automatic model_step(input logic night, input logic pm, input logic si, output exp_t e);
    logic done;
    logic so;
    done = 1'b0;
    so   = 1'b0;
    case (m_seg)
      0: if (night) begin m_seg = 1; m_el = 0; m_alt = pm; end
      1: begin
        m_el++;
        if (m_el == EH) begin
          m_el = 0;
          if (night) begin m_seg = 2; m_on = 1'b1; so = 1'b1; end
          else m_seg = 3;
        end
      end
      2: begin
        m_el++;
        if (m_el == HP && !night) begin
          m_seg = 3; m_el = 0;
        end else if (si) begin
          so = !m_on; m_on = 1'b1; m_el = 0;
        end else if (m_el == HP) begin
          m_on = !m_on; so = m_on; m_el = 0;
        end
      end
      default: begin
        m_el++;
        if (m_el == XH) begin m_seg = 0; m_el = 0; done = 1'b1; end
      end
    endcase
    for (int i = 0; i < NL; i++)
      e.ly[i] = (m_seg == 0) ? 1'b0 :
                (m_seg == 2) ? (m_on ^ (m_alt && (i % 2 == 1))) : 1'b1;
    e.act  = (m_seg != 0);
    e.done = done;
    e.so   = so;
  endtask

  // Monitor: one registered response per clock after the driver has queued it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("lane_yellow", 32'(bus.lane_yellow), 32'(e.ly));
        check("active", 32'(bus.active), 32'(e.act));
        check("exit_done", 32'(bus.exit_done), 32'(e.done));
`ifdef FLASH_SYNC_EN
        check("sync_out", 32'(bus.sync_out), 32'(e.so));
`endif
      end
    end
  end

  initial begin
    exp_t e;
    int   hold;
    logic night;
    logic pm;
    logic si;
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.night_en = 1'b0;
    bus.phase_mode = 1'b0;
`ifdef FLASH_SYNC_EN
    bus.sync_in = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_lanes", 32'(bus.lane_yellow), 32'd0);
    check("reset_active", 32'(bus.active), 32'd0);
    check("reset_done", 32'(bus.exit_done), 32'd0);
    reset_n = 1'b1;

    // Idle stretch: night_en low for 10 cycles must keep everything dark.
    for (int c = 0; c < 10; c++) begin
      model_step(1'b0, 1'b0, 1'b0, e);
      q.push_back(e);
      @(negedge clk);
    end

    hold  = 0;
    night = 1'b0;
    for (int c = 0; c < 900; c++) begin
      if (c == 450 || (c > 60 && $urandom_range(0, 149) == 0)) begin
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_lanes", 32'(bus.lane_yellow), 32'd0);
        check("async_rst_active", 32'(bus.active), 32'd0);
        check("async_rst_done", 32'(bus.exit_done), 32'd0);
        reset_n = 1'b1;
        model_reset();
        q.delete();
      end
      if (hold == 0) begin
        night = $urandom_range(0, 1);
        hold  = ($urandom_range(0, 4) == 0) ? 1 : $urandom_range(1, 16);
      end
      hold--;
      pm = $urandom_range(0, 1);
`ifdef FLASH_SYNC_EN
      si = ($urandom_range(0, 11) == 0);
      bus.sync_in = si;
`else
      si = 1'b0;
`endif
      bus.night_en   = night;
      bus.phase_mode = pm;
      model_step(night, pm, si, e);
      q.push_back(e);
      @(negedge clk);
    end

    @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_mode_ctrl.md
Name: flash_mode_ctrl

Overview:
- Parametrised night/flash-mode lamp controller for N traffic lanes.
- Driven from the system clock with an internal half-period prescaler.
- Provides a steady-yellow entry and exit hold, plus in-phase or alternating (odd/even) blinking.
- Hands control back to the day-mode sequencer with a one-cycle exit_done pulse.

Parameters:
NUM_LANES, 2, number of lane yellow outputs (>=1)
HALF_PERIOD, 1, clk cycles per blink half-period (>=1; 1 with a 1 Hz clk reproduces 1 s toggling)
ENTRY_HOLD, 2, clk cycles of steady all-yellow before flashing starts (>=1)
EXIT_HOLD, 2, clk cycles of steady all-yellow before returning to idle (>=1)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
night_en  input  1  level request for flash mode
phase_mode  input  1  0 = all lanes in phase; 1 = odd-indexed lanes inverted
lane_yellow  output  NUM_LANES  yellow lamp drive, registered
active  output  1  high whenever state != IDLE, registered
exit_done  output  1  one-cycle pulse on EXIT->IDLE, registered

Behaviour:
- Reset (reset_n low, async): state=IDLE, cnt=0, ph=0, mode_q=0, lane_yellow=0, active=0, exit_done=0.
- All outputs are registered and change only on the rising edge of clk (except reset).
- States: IDLE, ENTRY, FLASH, EXIT. cnt is an internal down-counter sized for max(HALF_PERIOD, ENTRY_HOLD, EXIT_HOLD).
- IDLE:
  - lane_yellow=0, active=0.
  - night_en=1 at an edge: go to ENTRY, cnt=ENTRY_HOLD-1, latch mode_q=phase_mode.
  - From that same edge, lane_yellow=all 1 and active=1.
- ENTRY:
  - lane_yellow=all 1.
  - cnt==0: if night_en=1 go to FLASH with ph=1, cnt=HALF_PERIOD-1. If night_en=0 go to EXIT, cnt=EXIT_HOLD-1.
  - Else cnt--.
- FLASH:
  - lane_yellow[i] = ph XOR (mode_q AND i odd).
  - At cnt==0: if night_en=1, toggle ph and reload cnt=HALF_PERIOD-1. If night_en=0, go to EXIT, cnt=EXIT_HOLD-1.
  - Else cnt--.
  - A night_en drop mid-half-period is honoured only at that half-period's end; no truncated blink.
- EXIT:
  - lane_yellow=all 1.
  - Completes unconditionally; night_en is ignored.
  - cnt==0: go to IDLE; exit_done=1 for exactly one cycle, coincident with lane_yellow=0 and active=0.
- phase_mode is sampled only on IDLE->ENTRY; later changes have no effect until the next entry.
- night_en re-asserted in IDLE on the cycle exit_done is high: re-enter ENTRY on the next edge (no lost request).
- Reset mid-operation: immediate return to the reset values; no exit_done pulse.
- With HALF_PERIOD=1, ph toggles every cycle in FLASH.

Optional Feature:
- Macro: FLASH_SYNC_EN.
- Defined:
  - Adds input sync_in (1 bit) and output sync_out (1 bit, registered).
  - sync_out pulses one cycle on every FLASH edge where ph goes 0->1, including the ENTRY->FLASH edge.
  - sync_in=1 while in FLASH forces ph=1 and cnt=HALF_PERIOD-1 at the next edge, overriding the toggle but not an exit decision.
  - Purpose: phase-locking adjacent intersections.
- Not defined: neither port exists; behaviour exactly as above.

Test Plan:
- Reset release: NUM_LANES=4, HALF_PERIOD=3, ENTRY_HOLD=2, EXIT_HOLD=2, night_en=0 for 10 cycles -> lane_yellow=4'b0000, active=0, exit_done never 1.
- In-phase entry: night_en=1 at edge t0, phase_mode=0 -> lane_yellow=4'b1111 at t0..t0+1. FLASH then follows 1111 x3 cycles, 0000 x3, 1111 x3; active=1 throughout.
- Alternating: phase_mode=1 at entry -> after 2 cycles of 1111, pattern 0101 x3, 1010 x3, repeating. Toggling phase_mode mid-FLASH changes nothing.
- Exit timing: night_en drops 1 cycle into a 3-cycle half-period -> that half completes, then 1111 for 2 cycles, then 0000 with exit_done=1 for exactly 1 cycle, active=0.
- Abort in ENTRY: night_en=1 for 1 cycle only -> 1111 for 2 cycles (ENTRY), 1111 for 2 cycles (EXIT), then exit_done pulse. No blink occurs.
- Async reset mid-FLASH: reset_n low between edges -> lane_yellow=0000, active=0 immediately, no exit_done. With FLASH_SYNC_EN, sync_in pulse mid-OFF half -> lanes on at the next edge, sync_out pulses.
